// File: rtl/if_id_pipe_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : if_id_pipe_buf_pkg                                        |
// | Shared constants, width helpers and entry type for the fetch/decode |
// | elastic buffer.                                                     |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package if_id_pipe_buf_pkg;

    localparam int DEF_INSTR_W = 32;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DEPTH   = 2;

    // Instruction presented to decode when the buffer holds nothing.
    localparam logic [DEF_INSTR_W-1:0] NOP_INSTR = '0;

    // Pointer width for a given depth; kept at least one bit wide.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int PTR_W     = ptr_width(DEF_DEPTH);
    localparam int CNT_OCC_W = PTR_W + 1;

    // One buffered fetch result at the default widths.
    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_ADDR_W-1:0]  addr;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/if_id_pipe_buf_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : if_id_pipe_buf_sat_counter                                |
// | Up-counter that sticks at its all-ones value; synchronous reset and |
// | synchronous clear.                                                  |
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module if_id_pipe_buf_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Count enabled cycles, holding at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/if_id_pipe_buf.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : if_id_pipe_buf                                            |
// | Elastic DEPTH-entry fetch/decode buffer with valid/ready on both    |
// | sides, hazard hold, multi-source flush and a saturating flush count.|
// | Rev     : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module if_id_pipe_buf
    import if_id_pipe_buf_pkg::*;
#(
    parameter int INSTR_W   = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 2,   // power of two, at least 2
    parameter int NUM_FLUSH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [INSTR_W-1:0]       instr_i,
    input  logic [ADDR_W-1:0]        addr_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [INSTR_W-1:0]       instr_o,
    output logic [ADDR_W-1:0]        addr_o,
    input  logic                     hd_i,
    input  logic [NUM_FLUSH-1:0]     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         flush_cnt_o
);

    localparam int c_ptr_w = ptr_width(DEPTH);
    localparam int c_occ_w = $clog2(DEPTH) + 1;
    localparam logic [c_occ_w-1:0] c_full = c_occ_w'(DEPTH);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
    } slot_t;

    slot_t              r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_occ_w-1:0] r_count;

    logic  w_push;
    logic  w_pop;
    logic  w_flush;
    slot_t w_head;

    // Handshake flags are derived only from registered occupancy, so
    // out_ready_i and hd_i never reach in_ready_o combinationally.
    assign in_ready_o  = (r_count < c_full);
    assign out_valid_o = (r_count != '0);
    assign w_flush     = |flush_i;
    assign w_push      = in_valid_i & in_ready_o;
    assign w_pop       = out_valid_o & out_ready_i & ~hd_i;

    // Head entry, replaced by a NOP whenever nothing is buffered.
    assign w_head  = r_mem[r_rd_ptr];
    assign instr_o = out_valid_o ? w_head.instr : '0;
    assign addr_o  = out_valid_o ? w_head.addr  : '0;
    assign count_o = r_count;

    // Storage write; contents are left as-is on reset and flush since
    // occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push && !w_flush && !rst_i) begin
            r_mem[r_wr_ptr] <= '{instr: instr_i, addr: addr_i};
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats
    // push/pop (a same-cycle push is dropped).
    always_ff @(posedge clk) begin
        if (rst_i || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    if_id_pipe_buf_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst_i),
        .clr (1'b0),
        .inc (w_flush),
        .cnt (flush_cnt_o)
    );

endmodule
`default_nettype wire
